fmult_accum_seq: RTL and testbench
==================================

# fmult_accum_seq

Sequencer for the shared FMULT datapath of the ADPCM predictor. It issues the eight predictor tap operations (b1..b6 against DQ history, then a2 and a1 against SR history) to one FMULT unit through a valid/ready handshake. It accumulates the returned WAn/WBn products modulo 2^16 and publishes the G.721 signal estimates SEZ and SE once per start. It sits between the per-channel control FSM and the FMULT/operand-fetch pipeline.

## Interface
- TIMEOUT, 15: the number of consecutive cycles with products outstanding and no wan_vld after which the pass is aborted. Range is 2..255.
- clk  in  1  block clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin one estimate pass; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse at the end of a pass.
- err  out  1  valid with done; 1 means the pass was aborted by timeout.
- tap_idx  out  3  tap being issued: 0..5 = b1..b6, 6 = a2, 7 = a1.
- tap_vld  out  1  tap_idx is valid.
- tap_rdy  in  1  FMULT accepts the tap; a transfer occurs when tap_vld & tap_rdy.
- wan  in  16  returned product, two's complement.
- wan_vld  in  1  wan is valid; products return in issue order.
- sez  out  15  SEZI[15:1]; updated only on a successful done.
- se  out  15  SEI[15:1]; updated only on a successful done.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 → ISSUE. Clear issue count icnt, return count rcnt, accumulator acc and timeout counter.
  - wan_vld in IDLE is ignored.
- ISSUE:
  - tap_vld=1 and tap_idx=icnt.
  - On each transfer, icnt increments.
  - After the transfer with icnt=7 → DRAIN, or → DONE if that cycle also returns the 8th product.
  - tap_idx holds stable while tap_rdy=0.
- Return path (ISSUE and DRAIN):
  - Each wan_vld adds wan to acc, acc = (acc + wan) mod 2^16, and increments rcnt.
  - When the 6th product is added, the post-add value is latched as sezi.
  - The 8th product's post-add value is sei.
  - wan_vld with rcnt=8 is ignored. wan_vld while rcnt ≥ icnt is also ignored; it counts as a spurious return.
- DRAIN:
  - tap_vld=0.
  - On the 8th return → DONE.
- DONE, one cycle:
  - done=1.
  - If err=0: sez<=sezi[15:1] and se<=sei[15:1], visible from the cycle after DONE.
  - If err=1: sez and se keep their previous values.
  - Next state is IDLE.
- Timeout:
  - tcnt counts cycles in ISSUE/DRAIN where rcnt<icnt and wan_vld=0; it clears on any wan_vld.
  - When tcnt reaches TIMEOUT → DONE with err=1.
  - Outstanding products that arrive later are ignored in IDLE.
  - A stall on tap_rdy with nothing outstanding never times out.
- start while busy is ignored; it is not queued.
- Reset, including mid-pass:
  - state=IDLE.
  - busy, done, err, tap_vld and tap_idx are 0.
  - sez, se, acc, all counters and sezi are 0.

## Timing
- Accepted start at edge 0: busy and tap_vld are high after edge 0, with tap_idx=0.
- With tap_rdy tied high, taps 0..7 issue on edges 1..8.
- With an FMULT latency of L cycles, the 8th wan_vld is sampled at edge 8+L. done is high in the following cycle, and sez/se update at the edge ending DONE.
- Minimum start-to-done is 9 cycles, with wan_vld in the same cycle as each issue.
- A new start is accepted no earlier than the cycle after DONE (IDLE). Back-to-back passes are therefore one idle cycle apart.
- done, err, busy, tap_vld and tap_idx are registered, with no combinational paths from inputs.

## Test plan
- Nominal pass:
  - Stimulus: reset, start, tap_rdy=1, FMULT model L=2, every wan=16'h0010.
  - Response: taps 0..7 in order; done exactly once, 11 cycles after start; err=0; sez=15'h0030, se=15'h0040.
- Wrap-around:
  - Stimulus: every wan=16'h4000.
  - Response: sezi=16'h8000, so sez=15'h4000; sei=16'h0000, so se=15'h0000.
- Negative products:
  - Stimulus: every wan=16'hFFFF.
  - Response: sez=15'h7FFD, se=15'h7FFC.
- Backpressure:
  - Stimulus: tap_rdy low for 3 cycles before taps 2 and 7; also pulse start mid-pass.
  - Response: tap_idx holds during each stall; no tap is skipped or duplicated; the extra start is ignored; results match the nominal pass.
- Timeout:
  - Stimulus: the model drops product 5; TIMEOUT=15.
  - Response: done with err=1 exactly 15 cycles after the last accepted wan_vld; sez/se keep their prior values; a following normal pass succeeds.
- Reset mid-pass:
  - Stimulus: assert reset after tap 4 is issued.
  - Response: all outputs are 0 asynchronously; late wan_vld pulses are ignored; the next start yields correct results.

Source files
------------

// File: rtl/fmult_accum_seq.sv
// Predictor tap sequencer for a shared FMULT unit: issues b1..b6, a2, a1 over a
// valid/ready handshake and sums the returned products into SEZ and SE.
module fmult_accum_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  tap_idx,
    output logic        tap_vld,
    input  logic        tap_rdy,
    input  logic [15:0] wan,
    input  logic        wan_vld,
    output logic [14:0] sez,
    output logic [14:0] se
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  icnt_r;
    logic [3:0]  icnt_s;
    logic [3:0]  rcnt_r;
    logic [3:0]  rcnt_s;
    logic [15:0] acc_r;
    logic [15:0] acc_s;
    logic [15:0] sum_s;
    logic [14:0] sezi_r;
    logic [14:0] sezi_s;
    logic [7:0]  tcnt_r;
    logic [7:0]  tcnt_s;
    logic [3:0]  icnt_eff_s;
    logic        active_s;
    logic        xfer_s;
    logic        ret_s;
    logic        err_s;

    // Next-state, counters and accumulator update.
    always_comb begin
        state_s    = state_r;
        icnt_s     = icnt_r;
        rcnt_s     = rcnt_r;
        acc_s      = acc_r;
        sezi_s     = sezi_r;
        tcnt_s     = tcnt_r;
        err_s      = 1'b0;
        active_s   = (state_r == ISSUE) || (state_r == DRAIN);
        xfer_s     = (state_r == ISSUE) && tap_vld && tap_rdy;
        // A product may return in the same cycle its tap is accepted.
        icnt_eff_s = icnt_r + {3'd0, xfer_s};
        ret_s      = active_s && wan_vld && (rcnt_r < icnt_eff_s);
        sum_s      = acc_r + wan;

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = ISSUE;
                    icnt_s  = 4'd0;
                    rcnt_s  = 4'd0;
                    acc_s   = 16'd0;
                    sezi_s  = 15'd0;
                    tcnt_s  = 8'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE, DRAIN: begin
                icnt_s = icnt_eff_s;
                if (ret_s) begin
                    acc_s  = sum_s;
                    rcnt_s = rcnt_r + 4'd1;
                    if (rcnt_r == 4'd5) begin
                        sezi_s = sum_s[15:1];
                    end else begin
                        sezi_s = sezi_r;
                    end
                end else begin
                    acc_s  = acc_r;
                    rcnt_s = rcnt_r;
                end
                // Only cycles with products owed and none arriving advance the timer.
                if (wan_vld) begin
                    tcnt_s = 8'd0;
                end else if (rcnt_r < icnt_r) begin
                    tcnt_s = tcnt_r + 8'd1;
                end else begin
                    tcnt_s = tcnt_r;
                end
                if (rcnt_s == 4'd8) begin
                    state_s = DONE;
                end else if (tcnt_s == TIMEOUT_C) begin
                    state_s = DONE;
                    err_s   = 1'b1;
                end else if (xfer_s && (icnt_r == 4'd7)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = state_r;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and accumulator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            icnt_r  <= 4'd0;
            rcnt_r  <= 4'd0;
            acc_r   <= 16'd0;
            sezi_r  <= 15'd0;
            tcnt_r  <= 8'd0;
        end else begin
            state_r <= state_s;
            icnt_r  <= icnt_s;
            rcnt_r  <= rcnt_s;
            acc_r   <= acc_s;
            sezi_r  <= sezi_s;
            tcnt_r  <= tcnt_s;
        end
    end

    // Registered control outputs decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            tap_vld <= 1'b0;
            tap_idx <= 3'd0;
        end else begin
            busy    <= (state_s != IDLE);
            done    <= (state_s == DONE);
            err     <= err_s;
            tap_vld <= (state_s == ISSUE);
            tap_idx <= (state_s == ISSUE) ? icnt_s[2:0] : 3'd0;
        end
    end

    // Estimates publish at the end of a successful DONE cycle only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sez <= 15'd0;
            se  <= 15'd0;
        end else if ((state_r == DONE) && !err) begin
            sez <= sezi_r;
            se  <= acc_r[15:1];
        end else begin
            sez <= sez;
            se  <= se;
        end
    end

endmodule

// File: tb/tb_fmult_accum_seq.sv
// Scoreboard bench for fmult_accum_seq with a latency-2 FMULT model that can
// drop one product; checks tap order, stalls, timing, timeout and reset.
module tb_fmult_accum_seq;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  tap_idx;
    logic        tap_vld;
    logic        tap_rdy;
    logic [15:0] wan;
    logic        wan_vld;
    logic [14:0] sez;
    logic [14:0] se;

    fmult_accum_seq #(.TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .tap_idx (tap_idx),
        .tap_vld (tap_vld),
        .tap_rdy (tap_rdy),
        .wan     (wan),
        .wan_vld (wan_vld),
        .sez     (sez),
        .se      (se)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    logic [2:0]  exp_tap_q[$];
    logic [30:0] exp_res_q[$];
    logic [14:0] exp_sez = 15'd0;
    logic [14:0] exp_se  = 15'd0;

    bit          s0v = 1'b0;
    bit          s1v = 1'b0;
    int          s0n = 0;
    int          s1n = 0;
    int          pnum = 0;
    int          drop_n = -1;
    logic [15:0] wval = 16'd0;
    int          cyc = 0;
    int          last_ret = 0;
    bit          last_xfer = 1'b0;

    // One clock: advance past the edge and step the FMULT model (latency 2).
    task automatic tick();
        bit x;
        bit rv;
        x  = tap_vld && tap_rdy;
        rv = wan_vld;
        @(posedge clk);
        #1;
        cyc++;
        if (rv) last_ret = cyc;
        s0v = s1v;
        s0n = s1n;
        s1v = x;
        s1n = pnum;
        if (x) pnum++;
        wan_vld = s0v && (s0n != drop_n);
        wan = wan_vld ? wval : 16'($urandom);
        last_xfer = x;
    endtask

    task automatic run_pass(input string nm, input logic [15:0] w, input bit bp,
                            input int drop, input int exp_lat);
        logic [15:0] s6;
        logic [15:0] s8;
        logic [30:0] er;
        logic [2:0]  e;
        logic [2:0]  prev_idx;
        bit          prev_vld;
        bit          got;
        int          c0;
        int          t;
        int          nstall;
        int          stall_cnt;
        wval = w;
        drop_n = drop;
        pnum = 0;
        s6 = w * 16'd6;
        s8 = w * 16'd8;
        exp_tap_q.delete();
        for (int i = 0; i < 8; i++) exp_tap_q.push_back(3'(i));
        if (drop < 0) begin
            exp_res_q.push_back({1'b0, s6[15:1], s8[15:1]});
            exp_sez = s6[15:1];
            exp_se  = s8[15:1];
        end else begin
            exp_res_q.push_back({1'b1, exp_sez, exp_se});
        end

        tap_rdy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        nvec++;
        if ({busy, tap_vld, tap_idx} !== 5'b11000) begin
            $display("FAIL %s start_response: got busy/vld/idx %b expected 11000", nm, {busy, tap_vld, tap_idx});
            nerr++;
        end

        got = 1'b0;
        nstall = 0;
        stall_cnt = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            if (bp && tap_vld && (tap_idx == 3'd2 || tap_idx == 3'd7) && stall_cnt < 3) begin
                tap_rdy = 1'b0;
                stall_cnt++;
            end else begin
                tap_rdy = 1'b1;
            end
            start = bp && ((cyc - c0) == 4);
            prev_idx = tap_idx;
            prev_vld = tap_vld;
            tick();
            start = 1'b0;
            t = cyc - c0;
            if (last_xfer) begin
                stall_cnt = 0;
                nvec++;
                if (exp_tap_q.size() == 0) begin
                    $display("FAIL %s tap_extra: got tap %0d expected none", nm, prev_idx);
                    nerr++;
                end else begin
                    e = exp_tap_q.pop_front();
                    if (prev_idx !== e) begin
                        $display("FAIL %s tap_order: got %0d expected %0d", nm, prev_idx, e);
                        nerr++;
                    end
                end
            end else if (prev_vld && tap_vld) begin
                nstall++;
                nvec++;
                if (tap_idx !== prev_idx) begin
                    $display("FAIL %s tap_hold: got %0d expected %0d", nm, tap_idx, prev_idx);
                    nerr++;
                end
            end
            if (done === 1'b1) begin
                got = 1'b1;
                nvec++;
                if (exp_lat >= 0 && t != exp_lat) begin
                    $display("FAIL %s done_latency: got %0d expected %0d", nm, t, exp_lat);
                    nerr++;
                end else if (exp_lat == -1 && cyc != last_ret + TMO) begin
                    $display("FAIL %s timeout_latency: got %0d expected %0d", nm, cyc - last_ret, TMO);
                    nerr++;
                end
                if (exp_res_q.size() == 0) begin
                    $display("FAIL %s spurious_done: got done expected none", nm);
                    nerr++;
                    er = {1'b0, exp_sez, exp_se};
                end else begin
                    er = exp_res_q.pop_front();
                end
                nvec++;
                if (err !== er[30]) begin
                    $display("FAIL %s err: got %b expected %b", nm, err, er[30]);
                    nerr++;
                end
                tick();
                nvec++;
                if ({done, busy} !== 2'b00) begin
                    $display("FAIL %s done_pulse: got done/busy %b expected 00", nm, {done, busy});
                    nerr++;
                end
                nvec++;
                if (sez !== er[29:15] || se !== er[14:0]) begin
                    $display("FAIL %s result: got sez %h se %h expected sez %h se %h", nm, sez, se, er[29:15], er[14:0]);
                    nerr++;
                end
            end
        end
        if (!got) begin
            nvec++;
            nerr++;
            $display("FAIL %s no_done: got no done in 300 cycles expected one", nm);
            exp_res_q.delete();
        end
        nvec++;
        if (exp_tap_q.size() != 0 || nstall != (bp ? 6 : 0)) begin
            $display("FAIL %s tap_count: got %0d missing taps %0d stalls expected 0 and %0d",
                     nm, exp_tap_q.size(), nstall, bp ? 6 : 0);
            nerr++;
        end
        tap_rdy = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        tap_rdy = 1'b1;
        wan_vld = 1'b0;
        wan = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        nvec++;
        if ({busy, done, err, tap_vld, tap_idx, sez, se} !== 37'd0) begin
            $display("FAIL reset_state: got %h expected 0", {busy, done, err, tap_vld, tap_idx, sez, se});
            nerr++;
        end
    endtask

    task automatic test_nominal();
        run_pass("nominal", 16'h0010, 1'b0, -1, 10);
        nvec++;
        if (sez !== 15'h0030 || se !== 15'h0040) begin
            $display("FAIL nominal_const: got sez %h se %h expected 0030 0040", sez, se);
            nerr++;
        end
    endtask

    task automatic test_wrap();
        run_pass("wrap", 16'h4000, 1'b0, -1, 10);
        nvec++;
        if (sez !== 15'h4000 || se !== 15'h0000) begin
            $display("FAIL wrap_const: got sez %h se %h expected 4000 0000", sez, se);
            nerr++;
        end
    endtask

    task automatic test_negative();
        run_pass("negative", 16'hFFFF, 1'b0, -1, 10);
        nvec++;
        if (sez !== 15'h7FFD || se !== 15'h7FFC) begin
            $display("FAIL negative_const: got sez %h se %h expected 7ffd 7ffc", sez, se);
            nerr++;
        end
    endtask

    task automatic test_backpressure();
        run_pass("backpressure", 16'h0010, 1'b1, -1, -2);
    endtask

    task automatic test_timeout();
        run_pass("timeout", 16'h0123, 1'b0, 4, -1);
    endtask

    task automatic test_back_to_back();
        run_pass("b2b_a", 16'h0200, 1'b0, -1, 10);
        run_pass("b2b_b", 16'h7001, 1'b0, -1, 10);
    endtask

    task automatic test_reset_mid_pass();
        bit ok;
        exp_tap_q.delete();
        exp_res_q.delete();
        wval = 16'h0555;
        drop_n = -1;
        pnum = 0;
        tap_rdy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 50 && pnum < 5; k++) tick();
        reset = 1'b1;
        #1;
        nvec++;
        if ({busy, done, err, tap_vld, tap_idx, sez, se} !== 37'd0) begin
            $display("FAIL reset_async: got %h expected 0", {busy, done, err, tap_vld, tap_idx, sez, se});
            nerr++;
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_sez = 15'd0;
        exp_se  = 15'd0;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if ({busy, done, tap_vld, sez, se} !== 33'd0) ok = 1'b0;
        end
        nvec++;
        if (!ok) begin
            $display("FAIL reset_late_wan: got activity after reset expected idle zeros");
            nerr++;
        end
        run_pass("after_reset", 16'h0010, 1'b0, -1, 10);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_wrap();
        test_negative();
        test_backpressure();
        test_timeout();
        test_back_to_back();
        test_reset_mid_pass();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
